line_window_gen: RTL and testbench
==================================

LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
- REQ-001 The block SHALL have parameter PIXEL_WIDTH, default 8: bits per pixel.
- REQ-002 The block SHALL have parameter KERNEL, default 3: window edge size; legal values are 3 and 5.
- REQ-003 The block SHALL have parameter MAX_COLS, default 64: line-buffer depth in pixels.
- REQ-004 The block SHALL have parameter DIM_WIDTH, default 8: width of the size fields.
- REQ-005 The block SHALL have these ports:
  - clk  in  1  sole clock, rising edge.
  - reset  in  1  synchronous, active-high reset.
  - start  in  1  one-cycle frame start; sampled only in IDLE.
  - row_size  in  DIM_WIDTH  frame rows; latched on start.
  - col_size  in  DIM_WIDTH  frame columns; latched on start.
  - stride  in  2  window step, 1 or 2; latched on start.
  - pix_data  in  PIXEL_WIDTH  raster-order input pixel.
  - pix_valid  in  1  input pixel valid.
  - pix_ready  out  1  input pixel accepted when pix_valid and pix_ready are both high.
  - win_data  out  KERNEL*KERNEL*PIXEL_WIDTH  packed window.
  - win_valid  out  1  window valid.
  - win_rdy  in  1  downstream accept.
  - win_last  out  1  final window of the frame; qualified by win_valid.
  - busy  out  1  high while not in IDLE.
  - done  out  1  one-cycle pulse at frame end.
  - size_err  out  1  one-cycle pulse on an illegal start.

Function
- REQ-006 The state machine SHALL have the states IDLE, RUN and FLUSH.
- REQ-007 IDLE to RUN SHALL occur on start with a legal configuration.
- REQ-008 A configuration SHALL be legal only when KERNEL <= row_size, KERNEL <= col_size <= MAX_COLS, and stride is 1 or 2.
- REQ-009 start with an illegal configuration SHALL pulse size_err and done in the next cycle, stay in IDLE, and emit no windows.
- REQ-010 start outside IDLE SHALL be ignored.
- REQ-011 pix_ready SHALL be high in RUN when (!win_valid || win_rdy), and low in IDLE and FLUSH.
- REQ-012 Each accepted pixel SHALL advance col_idx; col_idx SHALL wrap to 0 at col_size-1 and then increment row_idx.
- REQ-013 Accepted pixels SHALL be written into KERNEL-1 line buffers (depth MAX_COLS) and a KERNEL x KERNEL shift-register window.
- REQ-014 An accepted pixel at (r,c) SHALL complete a window when r >= KERNEL-1, c >= KERNEL-1, (r-KERNEL+1) mod stride == 0 and (c-KERNEL+1) mod stride == 0.
- REQ-015 A completed window SHALL appear on win_data with win_valid high in the cycle after the completing pixel is accepted (latency 1).
- REQ-016 Window element (i,j) SHALL occupy win_data bits [(i*KERNEL+j+1)*PIXEL_WIDTH-1 : (i*KERNEL+j)*PIXEL_WIDTH], with i=0 the oldest row and j=0 the oldest column.
- REQ-017 win_valid and win_data SHALL hold stable until win_rdy is high; no window SHALL be dropped or duplicated.
- REQ-018 Pixels accepted in the same cycle as a window handshake SHALL be allowed (full throughput, one window per cycle at stride 1).
- REQ-019 Windows SHALL never span a row boundary; the window shift register SHALL restart at c=0.
- REQ-020 The number of windows per frame SHALL be ((row_size-KERNEL)/stride+1) * ((col_size-KERNEL)/stride+1), using integer division.
- REQ-021 win_last SHALL be high with the last window of the frame.
- REQ-022 Acceptance of pixel (row_size-1, col_size-1) SHALL move the block to FLUSH.
- REQ-023 FLUSH SHALL wait until the output register is empty, then pulse done for one cycle and return to IDLE.
- REQ-024 Trailing rows or columns not reachable by the stride SHALL be consumed but SHALL produce no window.
- REQ-025 Line-buffer contents SHALL be unspecified at frame start; no window SHALL depend on data from the previous frame.

Reset
- REQ-026 While reset is high at a clk edge: state=IDLE, row_idx=0, col_idx=0, win_valid=0, win_last=0, pix_ready=0, busy=0, done=0, size_err=0.
- REQ-027 win_data SHALL be don't-care after reset.
- REQ-028 Reset mid-frame SHALL abort the frame with no done pulse.
- REQ-029 The next start after reset SHALL behave as a fresh frame.
- REQ-030 Line-buffer RAM SHALL NOT require reset.

Verification
- REQ-031 KERNEL=3, 5x5 frame, stride 1, pixels 0..24, win_rdy=1 -> the bench SHALL see 9 windows; first 0,1,2,5,6,7,10,11,12; last 12,13,14,17,18,19,22,23,24 with win_last=1; done 1 cycle after it.
- REQ-032 Same frame with stride 2 -> the bench SHALL see 4 windows with top-left pixels 0, 2, 10, 12; win_last on the 4th.
- REQ-033 Stride 1, win_rdy toggling 1,0,0,1 repeatedly -> the bench SHALL see the same 9 windows in order, win_data stable while stalled, and pix_ready low whenever win_valid && !win_rdy.
- REQ-034 start with col_size=2 (or col_size=MAX_COLS+1) -> size_err=1 and done=1 in the next cycle, busy stays 0, no win_valid.
- REQ-035 Reset asserted after 12 pixels, then a new 5x5 frame -> no done for the aborted frame; second frame output identical to REQ-031.
- REQ-036 start pulsed during RUN -> ignored; window count and order unchanged.

Source files
------------

// File: rtl/line_window_gen.sv
// line_window_gen: turns a raster pixel stream into KERNEL x KERNEL sliding windows
// using KERNEL-1 line buffers, stride 1 or 2, and a one-deep output register.
module line_window_gen #(
   parameter int PIXEL_WIDTH = 8,
   parameter int KERNEL      = 3,
   parameter int MAX_COLS    = 64,
   parameter int DIM_WIDTH   = 8
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [DIM_WIDTH-1:0]                 row_size,
   input  logic [DIM_WIDTH-1:0]                 col_size,
   input  logic [1:0]                           stride,
   input  logic [PIXEL_WIDTH-1:0]               pix_data,
   input  logic                                 pix_valid,
   output logic                                 pix_ready,
   output logic [KERNEL*KERNEL*PIXEL_WIDTH-1:0] win_data,
   output logic                                 win_valid,
   input  logic                                 win_rdy,
   output logic                                 win_last,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 size_err
);
   localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
   localparam int WW = KERNEL*KERNEL*PIXEL_WIDTH;
   localparam logic [DIM_WIDTH:0]   K_EXT    = (DIM_WIDTH+1)'(KERNEL);
   localparam logic [DIM_WIDTH:0]   MAXC_EXT = (DIM_WIDTH+1)'(MAX_COLS);
   localparam logic [DIM_WIDTH-1:0] KM1      = DIM_WIDTH'(KERNEL-1);
   localparam logic [DIM_WIDTH-1:0] ONE      = DIM_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                 state_q, state_d;
   logic [DIM_WIDTH-1:0]   rows_q, rows_d;
   logic [DIM_WIDTH-1:0]   cols_q, cols_d;
   logic [1:0]             stride_q, stride_d;
   logic [DIM_WIDTH-1:0]   row_idx_q, row_idx_d;
   logic [DIM_WIDTH-1:0]   col_idx_q, col_idx_d;
   logic                   win_valid_q, win_valid_d;
   logic                   win_last_q, win_last_d;
   logic                   done_q, done_d;
   logic                   size_err_q, size_err_d;
   logic [WW-1:0]          win_data_q, win_data_d;

   logic [PIXEL_WIDTH-1:0] lb_mem   [KERNEL-1][MAX_COLS];
   logic [PIXEL_WIDTH-1:0] col_vec  [KERNEL];
   logic [PIXEL_WIDTH-1:0] win_sr_q [KERNEL][KERNEL];
   logic [PIXEL_WIDTH-1:0] win_sr_d [KERNEL][KERNEL];
   logic [AW-1:0]          lb_addr;

   logic accept, cfg_legal, win_hit, win_is_last, at_last_pix;

   assign pix_ready = (state_q == RUN) && (!win_valid_q || win_rdy);
   assign accept    = pix_ready && pix_valid;
   assign lb_addr   = col_idx_q[AW-1:0];

   assign cfg_legal = ({1'b0, row_size} >= K_EXT) && ({1'b0, col_size} >= K_EXT) &&
                      ({1'b0, col_size} <= MAXC_EXT) && ((stride == 2'd1) || (stride == 2'd2));

   // (r-K+1) is even exactly when r and K-1 share their LSB
   assign win_hit = (row_idx_q >= KM1) && (col_idx_q >= KM1) &&
                    ((stride_q == 2'd1) ||
                     ((row_idx_q[0] == KM1[0]) && (col_idx_q[0] == KM1[0])));

   assign win_is_last =
      (({1'b0, row_idx_q} + {{(DIM_WIDTH-1){1'b0}}, stride_q}) >= {1'b0, rows_q}) &&
      (({1'b0, col_idx_q} + {{(DIM_WIDTH-1){1'b0}}, stride_q}) >= {1'b0, cols_q});

   assign at_last_pix = (row_idx_q == rows_q - ONE) && (col_idx_q == cols_q - ONE);

   // Column entering the window: oldest buffered row first, live pixel last
   always_comb begin
      for (int unsigned i = 0; i < KERNEL-1; i++) begin
         col_vec[i] = lb_mem[i][lb_addr];
      end
      col_vec[KERNEL-1] = pix_data;
   end

   always_comb begin
      win_sr_d    = win_sr_q;
      win_data_d  = win_data_q;
      win_valid_d = win_valid_q;
      win_last_d  = win_last_q;
      if (win_valid_q && win_rdy) begin
         win_valid_d = 1'b0;
         win_last_d  = 1'b0;
      end
      if (accept) begin
         for (int unsigned i = 0; i < KERNEL; i++) begin
            for (int unsigned j = 0; j < KERNEL-1; j++) begin
               win_sr_d[i][j] = win_sr_q[i][j+1];
            end
            win_sr_d[i][KERNEL-1] = col_vec[i];
         end
         if (win_hit) begin
            win_valid_d = 1'b1;
            win_last_d  = win_is_last;
            for (int unsigned i = 0; i < KERNEL; i++) begin
               for (int unsigned j = 0; j < KERNEL; j++) begin
                  win_data_d[(i*KERNEL+j)*PIXEL_WIDTH +: PIXEL_WIDTH] = win_sr_d[i][j];
               end
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      stride_d   = stride_q;
      row_idx_d  = row_idx_q;
      col_idx_d  = col_idx_q;
      done_d     = 1'b0;
      size_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_legal) begin
                  state_d   = RUN;
                  rows_d    = row_size;
                  cols_d    = col_size;
                  stride_d  = stride;
                  row_idx_d = '0;
                  col_idx_d = '0;
               end else begin
                  size_err_d = 1'b1;
                  done_d     = 1'b1;
               end
            end
         end
         RUN: begin
            if (accept) begin
               if (col_idx_q == cols_q - ONE) begin
                  col_idx_d = '0;
                  row_idx_d = row_idx_q + ONE;
               end else begin
                  col_idx_d = col_idx_q + ONE;
               end
               if (at_last_pix) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (!win_valid_d) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rows_q      <= '0;
         cols_q      <= '0;
         stride_q    <= 2'd1;
         row_idx_q   <= '0;
         col_idx_q   <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         done_q      <= 1'b0;
         size_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
         stride_q    <= stride_d;
         row_idx_q   <= row_idx_d;
         col_idx_q   <= col_idx_d;
         win_valid_q <= win_valid_d;
         win_last_q  <= win_last_d;
         done_q      <= done_d;
         size_err_q  <= size_err_d;
      end
   end

   always_ff @(posedge clk) begin
      win_sr_q   <= win_sr_d;
      win_data_q <= win_data_d;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned i = 0; i < KERNEL-1; i++) begin
            lb_mem[i][lb_addr] <= col_vec[i+1];
         end
      end
   end

   assign win_data  = win_data_q;
   assign win_valid = win_valid_q;
   assign win_last  = win_last_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign size_err  = size_err_q;

endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen: directed and random frames compared against a window
// list built straight from the frame pixels, plus illegal-start and reset cases.
module tb_line_window_gen;
   localparam int PW = 8;
   localparam int K  = 3;
   localparam int MC = 64;
   localparam int DW = 8;
   localparam int WW = K*K*PW;

   logic          clk = 1'b0;
   logic          reset, start, pix_valid, pix_ready, win_valid, win_rdy, win_last;
   logic          busy, done, size_err;
   logic [DW-1:0] row_size, col_size;
   logic [1:0]    stride;
   logic [PW-1:0] pix_data;
   logic [WW-1:0] win_data;
   int            vec_cnt  = 0;
   int            miss_cnt = 0;

   line_window_gen #(
      .PIXEL_WIDTH(PW),
      .KERNEL(K),
      .MAX_COLS(MC),
      .DIM_WIDTH(DW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .row_size(row_size),
      .col_size(col_size),
      .stride(stride),
      .pix_data(pix_data),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .win_data(win_data),
      .win_valid(win_valid),
      .win_rdy(win_rdy),
      .win_last(win_last),
      .busy(busy),
      .done(done),
      .size_err(size_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; pix_valid = 1'b0; win_rdy = 1'b1;
      @(negedge clk); #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_size_err", size_err, 1'b0);
      chk("rst_win_valid", win_valid, 1'b0);
      chk("rst_win_last", win_last, 1'b0);
      chk("rst_pix_ready", pix_ready, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk); #1;
         chk("post_rst_done", done, 1'b0);
         chk("post_rst_busy", busy, 1'b0);
      end
   endtask

   task automatic illegal_start(input int rows, input int cols, input int strd);
      @(negedge clk);
      row_size = DW'(rows); col_size = DW'(cols); stride = 2'(strd);
      start = 1'b1; win_rdy = 1'b1; pix_valid = 1'b0;
      #1;
      chk("ill_busy_at_start", busy, 1'b0);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("ill_size_err", size_err, 1'b1);
      chk("ill_done", done, 1'b1);
      chk("ill_busy", busy, 1'b0);
      chk("ill_win_valid", win_valid, 1'b0);
      @(negedge clk); #1;
      chk("ill_size_err_clr", size_err, 1'b0);
      chk("ill_done_clr", done, 1'b0);
      chk("ill_busy_after", busy, 1'b0);
      chk("ill_win_valid_after", win_valid, 1'b0);
   endtask

   // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
   task automatic run_frame(input int rows, input int cols, input int strd, input int rdy_mode,
                            input bit pv_rand, input bit dat_rand, input int mid_start,
                            input int abort_after);
      logic [PW-1:0] fr[];
      logic [WW-1:0] exp_q[$];
      bit            last_q[$];
      int            comp_q[$];
      logic [WW-1:0] w;
      int            npix, nwr, nwc, nexp, n_acc, rel, got, n_p, n_w, done_cyc, c;
      bit            finished;
      npix = rows * cols;
      fr   = new[npix];
      foreach (fr[p]) fr[p] = dat_rand ? PW'($urandom) : PW'(p);
      nwr = (rows - K) / strd + 1;
      nwc = (cols - K) / strd + 1;
      for (int wr = 0; wr < nwr; wr++) begin
         for (int wc = 0; wc < nwc; wc++) begin
            w = '0;
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++)
                  w[(i*K+j)*PW +: PW] = fr[(wr*strd + i)*cols + wc*strd + j];
            exp_q.push_back(w);
            last_q.push_back((wr == nwr-1) && (wc == nwc-1));
            comp_q.push_back((wr*strd + K-1)*cols + wc*strd + K-1);
         end
      end
      nexp = exp_q.size();
      n_acc = 0; rel = 0; got = 0; n_p = -1; n_w = -1; done_cyc = -1; finished = 1'b0;
      for (c = 0; (c < npix*8 + 100) && !finished; c++) begin
         @(negedge clk);
         start = (c == 0) || (c == mid_start);
         if (c == 0) begin
            row_size = DW'(rows); col_size = DW'(cols); stride = 2'(strd);
         end else if (c == mid_start) begin
            row_size = DW'(K); col_size = DW'(K); stride = 2'd2;
         end
         case (rdy_mode)
            0:       win_rdy = 1'b1;
            1:       win_rdy = ((c % 4) == 0) || ((c % 4) == 3);
            default: win_rdy = 1'($urandom_range(0, 1));
         endcase
         pix_valid = (n_acc < npix) && (!pv_rand || ($urandom_range(0, 3) != 0));
         pix_data  = (n_acc < npix) ? fr[n_acc] : '0;
         #1;
         chk("busy", busy, (c >= 1) && ((done_cyc < 0) || (c < done_cyc)));
         chk("done", done, c == done_cyc);
         chk("size_err", size_err, 1'b0);
         chk("win_valid", win_valid, rel > got);
         chk("pix_ready", pix_ready, (c >= 1) && (n_p < 0) && (!win_valid || win_rdy));
         if (win_valid === 1'b1) begin
            if (got < nexp) begin
               chk("win_data", win_data, exp_q[got]);
               chk("win_last", win_last, last_q[got]);
            end else begin
               chk("extra_window", got + 1, nexp);
            end
            if (win_rdy) begin
               if ((got < nexp) && last_q[got]) n_w = c;
               got++;
            end
         end
         if (pix_valid && (pix_ready === 1'b1)) begin
            if ((rel < nexp) && (comp_q[rel] == n_acc)) rel++;
            n_acc++;
            if (n_acc == npix) n_p = c;
         end
         if ((n_p >= 0) && (n_w >= 0) && (done_cyc < 0))
            done_cyc = ((n_w > n_p + 1) ? n_w : n_p + 1) + 1;
         if (c == done_cyc) finished = 1'b1;
         if ((abort_after > 0) && (n_acc == abort_after)) break;
      end
      start = 1'b0;
      if (abort_after > 0) begin
         chk("abort_point", n_acc, abort_after);
         do_reset();
      end else begin
         chk("frame_done", finished, 1'b1);
         chk("win_count", got, nexp);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; row_size = '0; col_size = '0; stride = 2'd1;
      pix_data = '0; pix_valid = 1'b0; win_rdy = 1'b1;
      do_reset();
      run_frame(5, 5, 1, 0, 1'b0, 1'b0, -1, 0);
      run_frame(5, 5, 2, 0, 1'b0, 1'b0, -1, 0);
      run_frame(5, 5, 1, 1, 1'b0, 1'b0, -1, 0);
      illegal_start(5, 2, 1);
      illegal_start(5, MC + 1, 1);
      illegal_start(2, 5, 1);
      illegal_start(5, 5, 0);
      illegal_start(5, 5, 3);
      run_frame(5, 5, 1, 0, 1'b0, 1'b0, -1, 12);
      run_frame(5, 5, 1, 0, 1'b0, 1'b0, -1, 0);
      run_frame(5, 5, 1, 0, 1'b0, 1'b0, 10, 0);
      run_frame(6, 6, 2, 0, 1'b0, 1'b0, -1, 0);
      run_frame(3, MC, 1, 2, 1'b1, 1'b1, -1, 0);
      run_frame(K, K, 2, 2, 1'b1, 1'b1, -1, 0);
      for (int t = 0; t < 8; t++) begin
         run_frame(int'($urandom_range(K, 12)), int'($urandom_range(K, 14)),
                   int'($urandom_range(1, 2)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), 1'b1, -1, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
